// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_add_ctrl                                                            |
// | Bit-serial adder: one shared 1-bit add cell stepped over WIDTH cycles,     |
// | with valid/ready handshakes on both the operand and the result side.       |
// | Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port for a - b.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               c_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               w_p;
  logic               w_s;
  logic               w_c;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   w_b_cap;
  logic               w_c_cap;

  // Subtraction is a + ~b + 1, so B is inverted once at capture time.
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_cap = sub ? ~b : b;
  assign w_c_cap = sub ? 1'b1 : cin;
`else
  assign w_b_cap = b;
  assign w_c_cap = cin;
`endif

  assign w_p   = a_q[0] ^ b_q[0];
  assign w_s   = w_p ^ c_q;
  assign w_c   = (a_q[0] & b_q[0]) | (c_q & w_p);
  assign acc_d = (acc_q >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= w_b_cap;
            c_q        <= w_c_cap;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= w_c;
          acc_q <= acc_d;
          cnt_q <= cnt_q + c_cnt_w'(1);
          if (cnt_q == c_last) begin
            sum_q       <= acc_d;
            cout_q      <= w_c;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// Testbench for serial_add_ctrl: vector table plus handshake corner cases,
// results checked through an expected-result queue.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_edge = -10;
  logic [8:0] exp_q[$];
  logic [8:0] e;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
  } vec_t;
  vec_t vq[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive operands and hold in_valid until accepted; returns the accept edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      input logic ts, input logic [8:0] ex, input bit keep,
                      output int acc_edge);
    int n;
    n = 0;
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'd0, in_ready}, 32'd1);
    acc_edge = -1;
    if (in_ready) begin
      @(posedge clk);
      if (keep) exp_q.push_back(ex);
      #1;
      acc_edge = cyc;
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard: pop an expected result at every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_edge = cyc + 1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got sum=%0h cout=%0b with no result required", sum, cout);
      end else begin
        e = exp_q.pop_front();
        chk("sum", {24'd0, sum}, {24'd0, e[7:0]});
        chk("cout", {31'd0, cout}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;
    int n;

    vq.push_back('{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0});
    vq.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vq.push_back('{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1});
    vq.push_back('{8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0});
    vq.push_back('{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1});
    vq.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vq.push_back('{8'hC3, 8'hC3, 1'b0, 1'b0, 8'h86, 1'b1});
    vq.push_back('{8'h55, 8'h2A, 1'b1, 1'b0, 8'h80, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
    vq.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    vq.push_back('{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0});
    vq.push_back('{8'h40, 8'h40, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: out_valid exactly WIDTH edges after accept, then one DONE cycle
    send(8'h3C, 8'h0F, 1'b0, 1'b0, 9'h04B, 1'b1, acc);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    chk("lat_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (7) @(posedge clk);
    #1;
    chk("lat_early_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_busy_run", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_done_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("lat_idle_busy", {31'd0, busy}, 32'd0);
    chk("lat_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("lat_idle_hold", {24'd0, sum}, 32'h4B);

    // Backpressure with ignored in_valid during DONE
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 1'b0, 9'h046, 1'b1, acc);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_sum_hold", {24'd0, sum}, 32'h46);
      chk("bp_cout_hold", {31'd0, cout}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_capture", {31'd0, busy}, 32'd0);

    // Reset after three bits processed
    send(8'h3C, 8'h0F, 1'b0, 1'b0, 9'h000, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_quiet", {31'd0, out_valid}, 32'd0);

    // Vector table
    foreach (vq[i]) begin
      send(vq[i].a, vq[i].b, vq[i].cin, vq[i].sub, {vq[i].cout, vq[i].sum}, 1'b1, acc);
    end

    // Back-to-back: second request accepted the edge after the handshake
    send(8'h01, 8'h02, 1'b0, 1'b0, 9'h003, 1'b1, acc);
    send(8'h80, 8'h80, 1'b0, 1'b0, 9'h100, 1'b1, acc2);
    chk("b2b_accept_edge", acc2, hs_edge + 1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
